prbs_check: RTL and testbench

//  Registered PRBS checker and lock monitor downstream of a PRBS generator/serdes. Feeds received words

---
 rtl/prbs_check.sv | 150 +++++++++++++++
 tb/tb_prbs_check.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_check.sv
// prbs_check: self-synchronising PRBS checker with lock FSM and a saturating bit-error counter.
// Define PRBS_CHECK_WORD_COUNT_EN to build the locked-word counter on word_count (constant 0 otherwise).
module prbs_check #(
  parameter int                    LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
  parameter int                    LFSR_INVERT   = 1,
  parameter int                    REVERSE       = 0,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    UNLOCK_ERRS   = 4,
  parameter int                    ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_valid,
  input  logic                     err_cnt_clear,
  output logic [DATA_WIDTH-1:0]    err_mask,
  output logic                     err_valid,
  output logic                     locked,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ERR_CNT_WIDTH-1:0] word_count
);

  localparam int PC_W   = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W  = ((ERR_CNT_WIDTH > PC_W) ? ERR_CNT_WIDTH : PC_W) + 1;
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                  fsm;
  logic [LFSR_WIDTH-1:0]   state_reg;
  logic [LFSR_WIDTH-1:0]   state_next;
  logic [DATA_WIDTH-1:0]   din_chk;
  logic [DATA_WIDTH-1:0]   din_ord;
  logic [DATA_WIDTH-1:0]   err_ord;
  logic [DATA_WIDTH-1:0]   core_err;
  logic                    core_clean;
  logic [PC_W-1:0]         core_pop;
  logic [GOOD_W-1:0]       good_cnt;
  logic [BAD_W-1:0]        bad_cnt;

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      n = n + PC_W'(v[i]);
    return n;
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_add(input logic [ERR_CNT_WIDTH-1:0] a,
                                                       input logic [PC_W-1:0]          b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({ERR_CNT_WIDTH{1'b1}}))
      return '1;
    return s[ERR_CNT_WIDTH-1:0];
  endfunction

  // Bring the word into "first received bit at the MSB" order so the core always walks MSB first.
  always_comb begin
    din_chk = (LFSR_INVERT != 0) ? ~data_in : data_in;
    for (int i = 0; i < DATA_WIDTH; i++)
      din_ord[i] = (REVERSE != 0) ? din_chk[DATA_WIDTH-1-i] : din_chk[i];
  end

  // Feed-forward Fibonacci core: the received bit itself enters the register, so no seeding is needed.
  always_comb begin
    logic fb;
    state_next = state_reg;
    err_ord    = '0;
    fb         = 1'b0;
    for (int i = DATA_WIDTH-1; i >= 0; i--) begin
      fb = state_next[LFSR_WIDTH-1];
      for (int j = 1; j < LFSR_WIDTH; j++)
        if (LFSR_POLY[j]) fb = fb ^ state_next[j-1];
      err_ord[i] = fb ^ din_ord[i];
      state_next = {state_next[LFSR_WIDTH-2:0], din_ord[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++)
      core_err[i] = (REVERSE != 0) ? err_ord[DATA_WIDTH-1-i] : err_ord[i];
    core_clean = (core_err == '0);
    core_pop   = popcount(core_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      err_mask  <= '0;
      err_valid <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
      fsm       <= HUNT;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      err_valid <= data_valid;
      if (data_valid) begin
        state_reg <= state_next;
        err_mask  <= core_err;
        if (fsm == HUNT) begin
          if (core_clean) begin
            if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
              fsm      <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end else begin
            good_cnt <= '0;
          end
        end else begin
          if (!core_clean) begin
            if (bad_cnt == BAD_W'(UNLOCK_ERRS - 1)) begin
              fsm     <= HUNT;
              locked  <= 1'b0;
              bad_cnt <= '0;
            end else begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end else begin
            bad_cnt <= '0;
          end
        end
      end
      // Clear beats a same-cycle increment; the unlocking word is still counted.
      if (err_cnt_clear)
        err_count <= '0;
      else if (data_valid && fsm == LOCKED)
        err_count <= sat_add(err_count, core_pop);
    end
  end

`ifdef PRBS_CHECK_WORD_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || err_cnt_clear)
      word_count <= '0;
    else if (data_valid && fsm == LOCKED && word_count != '1)
      word_count <= word_count + 1'b1;
  end
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_prbs_check.sv
// Scoreboard bench for prbs_check: a full-width DUT and a 4-bit-counter DUT share one inverted PRBS31 stream.
module tb_prbs_check;

`ifdef PRBS_CHECK_WORD_COUNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        err_cnt_clear = 1'b0;

  logic [7:0]  a_err_mask, b_err_mask;
  logic        a_err_valid, b_err_valid;
  logic        a_locked, b_locked;
  logic [31:0] a_err_count, a_word_count;
  logic [3:0]  b_err_count, b_word_count;

  always #5 clk = ~clk;

  prbs_check dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .err_cnt_clear(err_cnt_clear),
    .err_mask(a_err_mask), .err_valid(a_err_valid), .locked(a_locked),
    .err_count(a_err_count), .word_count(a_word_count)
  );

  prbs_check #(.ERR_CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .err_cnt_clear(err_cnt_clear),
    .err_mask(b_err_mask), .err_valid(b_err_valid), .locked(b_locked),
    .err_count(b_err_count), .word_count(b_word_count)
  );

  typedef struct {
    logic [7:0]  mask;
    logic        lock;
    logic [31:0] c32;
    logic [3:0]  c4;
    logic [31:0] w32;
    logic [3:0]  w4;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   started = 1'b0;
  logic ev_exp = 1'b0;

  // Transmitter: PRBS31 (x^31 + x^28 + 1), sent inverted, MSB first. gen[0] is the newest bit.
  logic [30:0] gen = 31'h1;
  // Reference checker state: history of de-inverted received bits, good/bad run lengths, counters.
  logic [30:0] mh = '0;
  int          m_good = 0, m_bad = 0;
  bit          m_lock = 1'b0;
  longint      m_c32 = 0, m_w32 = 0;
  int          m_c4 = 0, m_w4 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] next_word();
    logic [7:0] w;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      b    = gen[30] ^ gen[27];
      gen  = {gen[29:0], b};
      w[i] = ~b;
    end
    return w;
  endfunction

  function automatic void model_reset();
    mh = '0; m_good = 0; m_bad = 0; m_lock = 1'b0;
    m_c32 = 0; m_w32 = 0; m_c4 = 0; m_w4 = 0;
  endfunction

  function automatic void model_clear();
    m_c32 = 0; m_w32 = 0; m_c4 = 0; m_w4 = 0;
  endfunction

  function automatic void model_word(input logic [7:0] w, input bit clr);
    logic [7:0] r, e;
    int         pc;
    exp_t       x;
    r = ~w;
    for (int i = 7; i >= 0; i--) begin
      e[i] = r[i] ^ mh[30] ^ mh[27];
      mh   = {mh[29:0], r[i]};
    end
    pc = $countones(e);
    if (m_lock) begin
      m_c32 = (m_c32 + pc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_c32 + pc;
      m_c4  = (m_c4 + pc > 15) ? 15 : m_c4 + pc;
      if (m_w32 < 64'hFFFF_FFFF) m_w32++;
      if (m_w4 < 15) m_w4++;
      if (e != 0) begin
        m_bad++;
        if (m_bad == 4) begin m_lock = 1'b0; m_bad = 0; end
      end else begin
        m_bad = 0;
      end
    end else begin
      if (e == 0) begin
        m_good++;
        if (m_good == 16) begin m_lock = 1'b1; m_good = 0; end
      end else begin
        m_good = 0;
      end
    end
    if (clr) model_clear();
    x.mask = e;
    x.lock = m_lock;
    x.c32  = m_c32[31:0];
    x.c4   = 4'(m_c4);
    x.w32  = WC_EN ? m_w32[31:0] : 32'h0;
    x.w4   = WC_EN ? 4'(m_w4) : 4'h0;
    q.push_back(x);
  endfunction

  // Drive one cycle: a valid word (next PRBS word XOR flip) or a held cycle with junk on data_in.
  task automatic issue(input logic [7:0] flip, input bit valid, input bit clr);
    logic [7:0] w;
    @(posedge clk); #1;
    data_valid    = valid;
    err_cnt_clear = clr;
    if (valid) begin
      w       = next_word() ^ flip;
      data_in = w;
      model_word(w, clr);
    end else begin
      data_in = 8'hA5;
      if (clr) model_clear();
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    data_valid    = 1'b0;
    err_cnt_clear = 1'b0;
  endtask

  task automatic words(input int n);
    for (int i = 0; i < n; i++) issue(8'h00, 1'b1, 1'b0);
  endtask

  always @(posedge clk) ev_exp <= rst ? 1'b0 : data_valid;

  always @(negedge clk) begin
    if (started) begin
      exp_t e;
      chk("err_valid_a", a_err_valid, ev_exp);
      chk("err_valid_b", b_err_valid, ev_exp);
      if (a_err_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("scoreboard_underflow", 64'd0, 64'd1);
        end else begin
          e = q.pop_front();
          chk("err_mask_a",   a_err_mask,   e.mask);
          chk("err_mask_b",   b_err_mask,   e.mask);
          chk("locked_a",     a_locked,     e.lock);
          chk("locked_b",     b_locked,     e.lock);
          chk("err_count_a",  a_err_count,  e.c32);
          chk("err_count_b",  b_err_count,  e.c4);
          chk("word_count_a", a_word_count, e.w32);
          chk("word_count_b", b_word_count, e.w4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1;
    started = 1'b1;
    chk("rst_err_mask",   a_err_mask,   8'h00);
    chk("rst_err_valid",  a_err_valid,  1'b0);
    chk("rst_locked",     a_locked,     1'b0);
    chk("rst_err_count",  a_err_count,  32'h0);
    chk("rst_word_count", a_word_count, 32'h0);
    chk("rst_err_count4", b_err_count,  4'h0);
    rst = 1'b0;

    // Seed 31'h1 leaves sync errors in word 4 only (mask 8'h12); words 5..20 clean -> lock after word 20.
    words(16);
    idle();
    chk("hunt_locked_w16", a_locked, 1'b0);
    chk("hunt_errcnt_w16", a_err_count, 32'h0);
    words(3);
    idle();
    chk("hunt_locked_w19", a_locked, 1'b0);
    words(1);
    idle();
    chk("lock_w20", a_locked, 1'b1);
    chk("lock_errcnt", a_err_count, 32'h0);

    // Single flip of bit 3: one error now, echo 8'h90 four words later (taps 28 and 31) -> 3 total.
    words(3);
    issue(8'h08, 1'b1, 1'b0);
    words(8);
    idle();
    chk("flip_errcnt_a", a_err_count, 32'd3);
    chk("flip_errcnt_b", b_err_count, 4'd3);
    chk("flip_locked", a_locked, 1'b1);

    // Four inverted words: 8+8+8+5 errors, lock drops on the 4th; 4-bit counter saturates.
    for (int i = 0; i < 4; i++) issue(8'hFF, 1'b1, 1'b0);
    idle();
    chk("unlock_locked", a_locked, 1'b0);
    chk("unlock_errcnt_a", a_err_count, 32'd32);
    chk("unlock_errcnt_b", b_err_count, 4'hF);

    // Relock with data_valid toggling; echo word 4 (8'h0E) restarts the run, lock after valid word 20.
    for (int i = 0; i < 19; i++) begin
      issue(8'h00, 1'b1, 1'b0);
      issue(8'h00, 1'b0, 1'b0);
    end
    idle();
    chk("relock_v19", a_locked, 1'b0);
    issue(8'h00, 1'b1, 1'b0);
    issue(8'h00, 1'b0, 1'b0);
    idle();
    chk("relock_v20", a_locked, 1'b1);
    chk("relock_errcnt", a_err_count, 32'd32);

    // Clear on the errored echo word: its errors are dropped, then one flip yields 3.
    issue(8'h08, 1'b1, 1'b0);
    words(3);
    issue(8'h00, 1'b1, 1'b1);
    idle();
    chk("clear_errcnt_a", a_err_count, 32'd0);
    chk("clear_errcnt_b", b_err_count, 4'd0);
    chk("clear_locked", a_locked, 1'b1);
    words(4);
    issue(8'h08, 1'b1, 1'b0);
    words(4);
    idle();
    chk("postclr_errcnt_a", a_err_count, 32'd3);
    chk("postclr_errcnt_b", b_err_count, 4'd3);
    chk("postclr_wc_a", a_word_count, WC_EN ? 32'd9 : 32'd0);

    // Six isolated single-bit flips: +18 on the wide counter, 4-bit counter pins at 4'hF.
    for (int k = 0; k < 6; k++) begin
      issue(8'h08, 1'b1, 1'b0);
      words(7);
    end
    idle();
    chk("sat_errcnt_a", a_err_count, 32'd21);
    chk("sat_errcnt_b", b_err_count, 4'hF);
    chk("sat_locked", b_locked, 1'b1);
    chk("sat_wc_a", a_word_count, WC_EN ? 32'd57 : 32'd0);
    chk("sat_wc_b", b_word_count, WC_EN ? 4'hF : 4'h0);

    // Reset mid-stream with data_valid high.
    @(posedge clk); #1;
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'h3C;
    model_reset();
    @(posedge clk); #1;
    chk("midrst_locked", a_locked, 1'b0);
    chk("midrst_err_valid", a_err_valid, 1'b0);
    chk("midrst_err_mask", a_err_mask, 8'h00);
    chk("midrst_errcnt_a", a_err_count, 32'h0);
    chk("midrst_errcnt_b", b_err_count, 4'h0);
    chk("midrst_wc_a", a_word_count, 32'h0);
    rst        = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
